// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM state encoding and access-size codes.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } lsu_state_e;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

endpackage

// File: rtl/lsu_data_align.sv
// Byte-order swap of the memory word, load extraction/extension and store merge.
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [31:0] word_le,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] le_word,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  // Memory presents the lowest-addressed byte in the top lane.
  assign le_word = {mem_rdata[7:0], mem_rdata[15:8], mem_rdata[23:16], mem_rdata[31:24]};

  always_comb begin
    load_data  = word_le;
    store_data = wdata;
    case (size)
      SIZE_B: begin
        load_data  = {{24{~is_unsigned & word_le[7]}}, word_le[7:0]};
        store_data = {word_le[31:8], wdata[7:0]};
      end
      SIZE_H: begin
        load_data  = {{16{~is_unsigned & word_le[15]}}, word_le[15:0]};
        store_data = {word_le[31:16], wdata[15:0]};
      end
      default: begin
        load_data  = word_le;
        store_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: request capture, access FSM and response generation.
// Sub-word stores do a read-modify-write so memory always sees full-word writes.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 512
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] word_q, word_d;

  logic        req_err;
  logic [31:0] le_word;
  logic [31:0] load_data;
  logic [31:0] store_data;

  lsu_data_align u_align (
    .mem_rdata  (mem_rdata),
    .word_le    (word_q),
    .size       (size_q),
    .is_unsigned(unsigned_q),
    .wdata      (wdata_q),
    .le_word    (le_word),
    .load_data  (load_data),
    .store_data (store_data)
  );

  assign req_err = (req_size == 2'b11)
                 || ((req_size == SIZE_H) && req_addr[0])
                 || ((req_size == SIZE_W) && (req_addr[1:0] != 2'b00))
                 || (req_addr > LAST_ADDR);

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    word_d     = word_q;
    req_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d       = req_we;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          err_d      = req_err;
          if (req_err)                           state_d = RESP;
          else if (req_we && req_size == SIZE_W) state_d = WRITE;
          else                                   state_d = READ;
        end
      end
      READ: begin
        word_d  = le_word;
        state_d = we_q ? WRITE : RESP;
      end
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      err_q      <= 1'b0;
      word_q     <= 32'h0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      word_q     <= word_d;
    end
  end

  // Outputs decode straight from the state flop, so reset drops mem_wen immediately.
  assign resp_valid = (state_q == RESP);
  assign resp_err   = (state_q == RESP) && err_q;
  assign resp_rdata = ((state_q == RESP) && !err_q && !we_q) ? load_data : 32'h0;
  assign mem_addr   = ((state_q == READ) || (state_q == WRITE)) ? addr_q : 32'h0;
  assign mem_wen    = (state_q == WRITE);
  assign mem_wdata  = (state_q == WRITE) ? store_data : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected responses,
// a negedge monitor pops and compares data, error flag and latency.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          wen_cnt = 0;
  logic [31:0] last_wdata = 32'h0;
  logic [7:0]  mem [0:511];

  load_store_unit #(.MEM_BYTES(512)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always_comb begin
    mem_rdata = 32'h0;
    if (mem_addr <= 32'd508)
      mem_rdata = {mem[mem_addr], mem[mem_addr+1], mem[mem_addr+2], mem[mem_addr+3]};
  end

  always @(posedge clock) begin
    if (mem_wen && mem_addr <= 32'd508)
      for (int i = 0; i < 4; i++) mem[mem_addr+i] = mem_wdata[8*i +: 8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (mem_wen) begin
      wen_cnt++;
      last_wdata = mem_wdata;
    end
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
        chk("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
        chk("resp_mem_idle", {mem_wen, mem_addr}, 33'h0);
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int lat);
    exp_t e;
    bit   acc = 1'b0;
    @(negedge clock);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (req_ready) begin
        e.rdata = er; e.err = ee; e.lat = lat; e.acc = cyc;
        exp_q.push_back(e);
        acc = 1'b1;
        @(posedge clock);
      end else begin
        @(negedge clock);
      end
    end
    if (!acc) chk("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    @(negedge clock);
    req_valid = 1'b0;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clock);
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'd1);
    chk({tag, "_resp"}, {30'h0, resp_valid, resp_err}, 32'd0);
    chk({tag, "_rdata"}, resp_rdata, 32'h0);
    chk({tag, "_maddr"}, mem_addr, 32'h0);
    chk({tag, "_wen"}, {31'h0, mem_wen}, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'h0);
  endtask

  initial begin
    int w0;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    mem[0] = 8'h44; mem[1] = 8'h33; mem[2] = 8'h22; mem[3] = 8'h11;
    mem[5] = 8'h80;
    mem[8] = 8'hAA; mem[9] = 8'hBB; mem[10] = 8'hCC; mem[11] = 8'hDD;

    #12;
    check_reset_outputs("reset");
    @(negedge clock); @(negedge clock);
    reset = 1'b0;

    issue(1'b0, SIZE_W, 1'b0, 32'd0, 32'h0, 32'h11223344, 1'b0, 2);
    #1 chk("busy_not_ready", {31'h0, req_ready}, 32'd0);
    issue(1'b0, SIZE_B, 1'b0, 32'd5, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    issue(1'b0, SIZE_B, 1'b1, 32'd5, 32'h0, 32'h00000080, 1'b0, 2);
    issue(1'b0, SIZE_H, 1'b0, 32'd4, 32'h0, 32'hFFFF8000, 1'b0, 2);
    drain();

    w0 = wen_cnt;
    issue(1'b1, SIZE_H, 1'b0, 32'd8, 32'h00001234, 32'h0, 1'b0, 3);
    drain();
    chk("half_store_wen_pulses", 32'(wen_cnt - w0), 32'd1);
    chk("half_store_wdata", last_wdata, 32'hDDCC1234);
    chk("half_store_mem", {mem[8], mem[9], mem[10], mem[11]}, 32'h3412CCDD);
    issue(1'b0, SIZE_W, 1'b0, 32'd8, 32'h0, 32'hDDCC1234, 1'b0, 2);

    w0 = wen_cnt;
    issue(1'b0, SIZE_W, 1'b0, 32'd2,   32'h0, 32'h0, 1'b1, 1);
    issue(1'b1, SIZE_B, 1'b0, 32'd509, 32'h55, 32'h0, 1'b1, 1);
    issue(1'b0, 2'b11,  1'b0, 32'd0,   32'h0, 32'h0, 1'b1, 1);
    issue(1'b0, SIZE_B, 1'b1, 32'd512, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b0, SIZE_W, 1'b0, 32'd508, 32'h0, 32'h0, 1'b0, 2);
    drain();
    chk("error_no_wen", 32'(wen_cnt - w0), 32'd0);
    chk("error_mem_509", {24'h0, mem[509]}, 32'h0);

    issue(1'b1, SIZE_W, 1'b0, 32'd16, 32'hCAFEF00D, 32'h0, 1'b0, 2);
    issue(1'b0, SIZE_W, 1'b0, 32'd16, 32'h0, 32'hCAFEF00D, 1'b0, 2);
    issue(1'b1, SIZE_B, 1'b0, 32'd17, 32'hFFFFFF5A, 32'h0, 1'b0, 3);
    issue(1'b0, SIZE_W, 1'b0, 32'd16, 32'h0, 32'hCAFE5A0D, 1'b0, 2);
    drain();

    // Abort a byte store while it is reading.
    w0 = wen_cnt;
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_size = SIZE_B; req_addr = 32'd12; req_wdata = 32'hEE;
    @(posedge clock);
    #1 req_valid = 1'b0;
    #1 reset = 1'b1;
    #1 check_reset_outputs("abort_read");
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    chk("abort_read_no_wen", 32'(wen_cnt - w0), 32'd0);
    chk("abort_read_mem", {24'h0, mem[12]}, 32'h0);

    // Abort a word store in WRITE: mem_wen must drop without waiting for a clock.
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_size = SIZE_W; req_addr = 32'd24; req_wdata = 32'h12345678;
    @(posedge clock);
    #1 req_valid = 1'b0;
    chk("write_wen_high", {31'h0, mem_wen}, 32'd1);
    #1 reset = 1'b1;
    #1 chk("abort_write_wen", {31'h0, mem_wen}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("post_reset_ready", {31'h0, req_ready}, 32'd1);
    issue(1'b0, SIZE_W, 1'b0, 32'd24, 32'h0, 32'h0, 1'b0, 2);
    issue(1'b0, SIZE_W, 1'b0, 32'd0,  32'h0, 32'h11223344, 1'b0, 2);
    drain();

    // Back-to-back with req_valid held high throughout.
    issue(1'b0, SIZE_W, 1'b0, 32'd0,  32'h0, 32'h11223344, 1'b0, 2);
    issue(1'b0, SIZE_B, 1'b1, 32'd5,  32'h0, 32'h00000080, 1'b0, 2);
    issue(1'b0, SIZE_H, 1'b0, 32'd1,  32'h0, 32'h0, 1'b1, 1);
    issue(1'b1, SIZE_B, 1'b0, 32'd20, 32'h77, 32'h0, 1'b0, 3);
    issue(1'b0, SIZE_B, 1'b1, 32'd20, 32'h0, 32'h00000077, 1'b0, 2);
    issue(1'b0, SIZE_H, 1'b1, 32'd8,  32'h0, 32'h00001234, 1'b0, 2);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
